// File: rtl/sram_tdp_param_if.sv
// ============================================================================
// Module      : sram_tdp_param_if
// Description : Dual-port SRAM request/response bundle (ports A and B, busy).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_tdp_param_if #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 10
);
    logic              cen_a;
    logic              wen_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wmsk_a;
    logic [DATA_W-1:0] wdata_a;
    logic [DATA_W-1:0] rdata_a;

    logic              cen_b;
    logic              wen_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wmsk_b;
    logic [DATA_W-1:0] wdata_b;
    logic [DATA_W-1:0] rdata_b;

    logic              busy;

    modport master (
        output cen_a, wen_a, addr_a, wmsk_a, wdata_a,
        output cen_b, wen_b, addr_b, wmsk_b, wdata_b,
        input  rdata_a, rdata_b, busy
    );

    modport slave (
        input  cen_a, wen_a, addr_a, wmsk_a, wdata_a,
        input  cen_b, wen_b, addr_b, wmsk_b, wdata_b,
        output rdata_a, rdata_b, busy
    );
endinterface

`default_nettype wire

// File: rtl/sram_tdp_param.sv
// ============================================================================
// Module      : sram_tdp_param
// Description : Parametrised true-dual-port SRAM with bit masks, optional
//               output register, collision resolution and clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_tdp_param #(
    parameter int                DATA_W         = 18,
    parameter int                ADDR_W         = 10,
    parameter int                OUT_REG        = 0,
    parameter int                COLLISION_MODE = 0,
    parameter int                CLEAR_ON_RST   = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL      = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_tdp_param_if.slave      bus
);

    localparam int                c_depth    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_cnt_last = '1;
    localparam logic [ADDR_W-1:0] c_cnt_one  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              w_busy;

    logic [DATA_W-1:0] r_mem [0:c_depth-1];

    logic              w_act_a, w_act_b;
    logic              w_wr_a, w_wr_b;
    logic              w_same;
    logic [DATA_W-1:0] w_old_a, w_old_b;
    logic [DATA_W-1:0] w_new_a, w_new_b;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_fin_a, w_fin_b;
    logic [DATA_W-1:0] w_rd_a, w_rd_b;
    logic [DATA_W-1:0] r_rd_a, r_rd_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == ST_CLEAR) begin
            w_cnt_nxt = r_cnt + c_cnt_one;
            if (r_cnt == c_cnt_last) begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    assign w_busy   = (r_state == ST_CLEAR);
    assign bus.busy = w_busy;

    // Requests are squashed while the sweep owns the array.
    assign w_act_a = ~bus.cen_a & ~w_busy;
    assign w_act_b = ~bus.cen_b & ~w_busy;
    assign w_wr_a  = w_act_a & ~bus.wen_a;
    assign w_wr_b  = w_act_b & ~bus.wen_b;
    assign w_same  = w_wr_a & w_wr_b & (bus.addr_a == bus.addr_b);

    assign w_old_a = r_mem[bus.addr_a];
    assign w_old_b = r_mem[bus.addr_b];
    assign w_new_a = (w_old_a & bus.wmsk_a) | (bus.wdata_a & ~bus.wmsk_a);
    assign w_new_b = (w_old_b & bus.wmsk_b) | (bus.wdata_b & ~bus.wmsk_b);

    // Loser's merge first, winner's unmasked bits layered on top.
    always_comb begin
        if (COLLISION_MODE != 0) begin
            w_merged = (w_new_a & bus.wmsk_b) | (bus.wdata_b & ~bus.wmsk_b);
        end else begin
            w_merged = (w_new_b & bus.wmsk_a) | (bus.wdata_a & ~bus.wmsk_a);
        end
    end

    assign w_fin_a = w_same ? w_merged : w_new_a;
    assign w_fin_b = w_same ? w_merged : w_new_b;
    assign w_rd_a  = w_wr_a ? w_fin_a : w_old_a;
    assign w_rd_b  = w_wr_b ? w_fin_b : w_old_b;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_busy) begin
                r_mem[r_cnt] <= CLEAR_VAL;
            end else begin
                if (w_wr_a) r_mem[bus.addr_a] <= w_fin_a;
                if (w_wr_b) r_mem[bus.addr_b] <= w_fin_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_a <= '0;
            r_rd_b <= '0;
        end else begin
            if (w_act_a) r_rd_a <= w_rd_a;
            if (w_act_b) r_rd_b <= w_rd_b;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              r_vld_a, r_vld_b;
            logic [DATA_W-1:0] r_out_a, r_out_b;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld_a <= 1'b0;
                    r_vld_b <= 1'b0;
                    r_out_a <= '0;
                    r_out_b <= '0;
                end else begin
                    r_vld_a <= w_act_a;
                    r_vld_b <= w_act_b;
                    if (r_vld_a) r_out_a <= r_rd_a;
                    if (r_vld_b) r_out_b <= r_rd_b;
                end
            end

            assign bus.rdata_a = r_out_a;
            assign bus.rdata_b = r_out_b;
        end else begin : g_no_out_reg
            assign bus.rdata_a = r_rd_a;
            assign bus.rdata_b = r_rd_b;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sram_tdp_param.sv
// ============================================================================
// Module      : tb_sram_tdp_param
// Description : Directed self-checking bench for sram_tdp_param.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_tdp_param;

    localparam logic [17:0] c_clr = 18'h2A5A5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sram_tdp_param_if #(.DATA_W(18), .ADDR_W(10)) if0 ();
    sram_tdp_param_if #(.DATA_W(18), .ADDR_W(10)) if1 ();
    sram_tdp_param_if #(.DATA_W(18), .ADDR_W(10)) if2 ();

    // dut0: defaults, dut1: port B wins collisions, dut2: output register
    sram_tdp_param #(.CLEAR_VAL(c_clr)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    sram_tdp_param #(.COLLISION_MODE(1), .CLEAR_VAL(c_clr)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    sram_tdp_param #(.OUT_REG(1), .CLEAR_VAL(c_clr)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if0.cen_a = 1'b1; if0.wen_a = 1'b1; if0.addr_a = '0; if0.wmsk_a = '0; if0.wdata_a = '0;
        if0.cen_b = 1'b1; if0.wen_b = 1'b1; if0.addr_b = '0; if0.wmsk_b = '0; if0.wdata_b = '0;
        if1.cen_a = 1'b1; if1.wen_a = 1'b1; if1.addr_a = '0; if1.wmsk_a = '0; if1.wdata_a = '0;
        if1.cen_b = 1'b1; if1.wen_b = 1'b1; if1.addr_b = '0; if1.wmsk_b = '0; if1.wdata_b = '0;
        if2.cen_a = 1'b1; if2.wen_a = 1'b1; if2.addr_a = '0; if2.wmsk_a = '0; if2.wdata_a = '0;
        if2.cen_b = 1'b1; if2.wen_b = 1'b1; if2.addr_b = '0; if2.wmsk_b = '0; if2.wdata_b = '0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (if0.busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", if0.busy); end
        checks++; if (if0.rdata_a !== 18'h0) begin errors++; $display("FAIL reset_rdata_a: got %h expected 0", if0.rdata_a); end
        checks++; if (if0.rdata_b !== 18'h0) begin errors++; $display("FAIL reset_rdata_b: got %h expected 0", if0.rdata_b); end
        checks++; if (if2.rdata_a !== 18'h0) begin errors++; $display("FAIL reset_outreg_rdata_a: got %h expected 0", if2.rdata_a); end
        n = 0;
        while (if0.busy === 1'b1 && n < 2000) begin
            if (n == 1000) begin
                if0.cen_a = 1'b0; if0.wen_a = 1'b0; if0.addr_a = 10'd5; if0.wdata_a = 18'h12345; if0.wmsk_a = '0;
            end else begin
                if0.cen_a = 1'b1; if0.wen_a = 1'b1;
            end
            n++;
            tick();
        end
        idle_all();
        checks++; if (n != 1024) begin errors++; $display("FAIL sweep_busy_cycles: got %0d expected 1024", n); end
        checks++; if (if0.rdata_a !== 18'h0) begin errors++; $display("FAIL busy_rdata_hold: got %h expected 0", if0.rdata_a); end
        checks++; if (if1.busy !== 1'b0 || if2.busy !== 1'b0) begin errors++; $display("FAIL sweep_done_others: got %b%b expected 00", if1.busy, if2.busy); end
    endtask

    task automatic test_clear_read();
        logic [9:0] addrs [4];
        addrs[0] = 10'd0; addrs[1] = 10'd511; addrs[2] = 10'd1023; addrs[3] = 10'd5;
        for (int i = 0; i < 4; i++) begin
            if0.cen_a = 1'b0; if0.addr_a = addrs[i];
            tick();
            checks++;
            if (if0.rdata_a !== c_clr) begin errors++; $display("FAIL clear_read addr %0d: got %h expected %h", addrs[i], if0.rdata_a, c_clr); end
        end
        idle_all();
    endtask

    task automatic test_masked_write();
        if0.cen_a = 1'b0; if0.wen_a = 1'b0; if0.addr_a = 10'd5; if0.wdata_a = 18'h3FFFF; if0.wmsk_a = '0;
        tick();
        idle_all();
        if0.cen_b = 1'b0; if0.wen_b = 1'b0; if0.addr_b = 10'd5; if0.wdata_b = 18'h00000; if0.wmsk_b = 18'h0FF00;
        tick();
        checks++; if (if0.rdata_b !== 18'h0FF00) begin errors++; $display("FAIL masked_write_through: got %h expected 0ff00", if0.rdata_b); end
        idle_all();
        if0.cen_a = 1'b0; if0.addr_a = 10'd5;
        tick();
        checks++; if (if0.rdata_a !== 18'h0FF00) begin errors++; $display("FAIL masked_write_read: got %h expected 0ff00", if0.rdata_a); end
        idle_all();
    endtask

    task automatic test_collision();
        if0.cen_a = 1'b0; if0.wen_a = 1'b0; if0.addr_a = 10'd9; if0.wdata_a = 18'h11111;
        if0.cen_b = 1'b0; if0.wen_b = 1'b0; if0.addr_b = 10'd9; if0.wdata_b = 18'h22222;
        if1.cen_a = 1'b0; if1.wen_a = 1'b0; if1.addr_a = 10'd9; if1.wdata_a = 18'h11111;
        if1.cen_b = 1'b0; if1.wen_b = 1'b0; if1.addr_b = 10'd9; if1.wdata_b = 18'h22222;
        tick();
        idle_all();
        if0.cen_a = 1'b0; if0.addr_a = 10'd9;
        if1.cen_a = 1'b0; if1.addr_a = 10'd9;
        tick();
        checks++; if (if0.rdata_a !== 18'h11111) begin errors++; $display("FAIL collision_a_wins: got %h expected 11111", if0.rdata_a); end
        checks++; if (if1.rdata_a !== 18'h22222) begin errors++; $display("FAIL collision_b_wins: got %h expected 22222", if1.rdata_a); end
        idle_all();
        if0.cen_a = 1'b0; if0.wen_a = 1'b0; if0.addr_a = 10'd9; if0.wdata_a = 18'h11111; if0.wmsk_a = 18'h3FF00;
        if0.cen_b = 1'b0; if0.wen_b = 1'b0; if0.addr_b = 10'd9; if0.wdata_b = 18'h22222; if0.wmsk_b = 18'h00000;
        tick();
        checks++; if (if0.rdata_a !== 18'h22211) begin errors++; $display("FAIL collision_partial_a: got %h expected 22211", if0.rdata_a); end
        checks++; if (if0.rdata_b !== 18'h22211) begin errors++; $display("FAIL collision_partial_b: got %h expected 22211", if0.rdata_b); end
        idle_all();
        if0.cen_a = 1'b0; if0.addr_a = 10'd9;
        if0.cen_b = 1'b0; if0.addr_b = 10'd9;
        tick();
        checks++; if (if0.rdata_a !== 18'h22211 || if0.rdata_b !== 18'h22211) begin errors++; $display("FAIL dual_read_same: got %h/%h expected 22211/22211", if0.rdata_a, if0.rdata_b); end
        // bits 17:8 masked on both ports, 7:0 contested (A wins)
        if0.wen_a = 1'b0; if0.wdata_a = 18'h00000; if0.wmsk_a = 18'h3FF00;
        if0.wen_b = 1'b0; if0.wdata_b = 18'h3FFFF; if0.wmsk_b = 18'h3FF00;
        tick();
        checks++; if (if0.rdata_a !== 18'h22200) begin errors++; $display("FAIL collision_both_masked: got %h expected 22200", if0.rdata_a); end
        idle_all();
        if0.cen_a = 1'b0; if0.wen_a = 1'b0; if0.addr_a = 10'd10; if0.wdata_a = 18'h0AAAA;
        if0.cen_b = 1'b0; if0.wen_b = 1'b0; if0.addr_b = 10'd11; if0.wdata_b = 18'h15555;
        tick();
        idle_all();
        if0.cen_a = 1'b0; if0.addr_a = 10'd11;
        if0.cen_b = 1'b0; if0.addr_b = 10'd10;
        tick();
        checks++; if (if0.rdata_a !== 18'h15555 || if0.rdata_b !== 18'h0AAAA) begin errors++; $display("FAIL dual_write_diff: got %h/%h expected 15555/0aaaa", if0.rdata_a, if0.rdata_b); end
        idle_all();
    endtask

    task automatic test_read_before_write();
        if0.cen_a = 1'b0; if0.wen_a = 1'b0; if0.addr_a = 10'd3; if0.wdata_a = 18'h00001;
        tick();
        if0.wdata_a = 18'h00002;
        if0.cen_b = 1'b0; if0.addr_b = 10'd3;
        tick();
        checks++; if (if0.rdata_b !== 18'h00001) begin errors++; $display("FAIL rbw_old_word: got %h expected 00001", if0.rdata_b); end
        checks++; if (if0.rdata_a !== 18'h00002) begin errors++; $display("FAIL rbw_write_through: got %h expected 00002", if0.rdata_a); end
        if0.cen_a = 1'b1; if0.wen_a = 1'b1;
        tick();
        checks++; if (if0.rdata_b !== 18'h00002) begin errors++; $display("FAIL rbw_new_word: got %h expected 00002", if0.rdata_b); end
        idle_all();
    endtask

    task automatic test_out_reg();
        if2.cen_a = 1'b0; if2.wen_a = 1'b0; if2.addr_a = 10'd20; if2.wdata_a = 18'h01357;
        tick();
        idle_all();
        tick();
        checks++; if (if2.rdata_a !== 18'h01357) begin errors++; $display("FAIL outreg_write_through: got %h expected 01357", if2.rdata_a); end
        if2.cen_a = 1'b0; if2.addr_a = 10'd21;
        tick();
        idle_all();
        checks++; if (if2.rdata_a !== 18'h01357) begin errors++; $display("FAIL outreg_latency_edge1: got %h expected 01357", if2.rdata_a); end
        tick();
        checks++; if (if2.rdata_a !== c_clr) begin errors++; $display("FAIL outreg_latency_edge2: got %h expected %h", if2.rdata_a, c_clr); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (if2.rdata_a !== c_clr) begin errors++; $display("FAIL outreg_hold cycle %0d: got %h expected %h", i, if2.rdata_a, c_clr); end
        end
        if2.cen_a = 1'b0; if2.wen_a = 1'b0; if2.addr_a = 10'd21; if2.wdata_a = 18'h00F0F; if2.wmsk_a = 18'h3F0F0;
        tick();
        idle_all();
        checks++; if (if2.rdata_a !== c_clr) begin errors++; $display("FAIL outreg_merge_edge1: got %h expected %h", if2.rdata_a, c_clr); end
        tick();
        checks++; if (if2.rdata_a !== 18'h2AFAF) begin errors++; $display("FAIL outreg_merge: got %h expected 2afaf", if2.rdata_a); end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (if0.rdata_a !== 18'h0 || if0.rdata_b !== 18'h0) begin errors++; $display("FAIL rst_rdata_zero: got %h/%h expected 0/0", if0.rdata_a, if0.rdata_b); end
        checks++; if (if2.rdata_a !== 18'h0) begin errors++; $display("FAIL rst_outreg_zero: got %h expected 0", if2.rdata_a); end
        repeat (299) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (if0.busy === 1'b1 && n < 2000) begin
            n++;
            tick();
        end
        checks++; if (n != 1024) begin errors++; $display("FAIL mid_sweep_busy_cycles: got %0d expected 1024", n); end
        if0.cen_a = 1'b0; if0.addr_a = 10'd5;
        tick();
        checks++; if (if0.rdata_a !== c_clr) begin errors++; $display("FAIL resweep_read: got %h expected %h", if0.rdata_a, c_clr); end
        idle_all();
    endtask

    initial begin
        idle_all();
        tick();
        test_reset();
        test_clear_read();
        test_masked_write();
        test_collision();
        test_read_before_write();
        test_out_reg();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
